// File: rtl/mac_job_sequencer.sv
// Job sequencer for the precision-scalable MAC: config handshake, operand streaming, pipeline drain, result hand-off.
// Optional stall counter on perf_stall is built when MAC_JOB_SEQUENCER_PERF_EN is defined.
module mac_job_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_prec,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_wgt,
  output logic [7:0]       mac_act,
  output logic [7:0]       mac_wgt,
  output logic [1:0]       mac_prec,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [55:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [55:0]      res_data,
  output logic [1:0]       res_prec,
  output logic [15:0]      perf_stall
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prec_q, prec_d;
  logic             job_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prec_q  <= prec_d;
    end
  end

  assign job_acc = (state_q == S_IDLE) && cfg_valid && (cfg_prec != 2'd3);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prec_d    = prec_q;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    in_ready  = 1'b0;
    mac_act   = '0;
    mac_wgt   = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_prec  = '0;
    mac_prec  = (state_q == S_IDLE) ? 2'd0 : prec_q;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_prec == 2'd3) begin
            cfg_err = 1'b1;
          end else begin
            prec_d  = cfg_prec;
            cnt_d   = cfg_len;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        mac_clr = 1'b1;
        state_d = (cnt_q != '0) ? S_RUN : S_FLUSH;
      end
      S_RUN: begin
        in_ready = 1'b1;
        mac_act  = in_act;
        mac_wgt  = in_wgt;
        mac_en   = in_valid;
        if (in_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Zero operands push the last product into the accumulator and leave a zero product behind.
        mac_en  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        res_data  = mac_result;
        res_prec  = prec_q;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MAC_JOB_SEQUENCER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_q <= '0;
    else if (job_acc)
      stall_q <= '0;
    else if (state_q == S_RUN && !in_valid && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural two-stage lane-split MAC attached.
module tb_mac_job_sequencer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cfg_valid, cfg_ready, cfg_err;
  logic [1:0]       cfg_prec;
  logic [LEN_W-1:0] cfg_len;
  logic             in_valid, in_ready;
  logic [7:0]       in_act, in_wgt, mac_act, mac_wgt;
  logic [1:0]       mac_prec, res_prec;
  logic             mac_en, mac_clr;
  logic [55:0]      mac_result, res_data;
  logic             res_valid, res_ready;
  logic [15:0]      perf_stall;

  int checks = 0;
  int errors = 0;

  mac_job_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prec(cfg_prec), .cfg_len(cfg_len), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .mac_act(mac_act), .mac_wgt(mac_wgt), .mac_prec(mac_prec), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_prec(res_prec),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // MAC model: product register feeding a lane-split accumulator.
  function automatic logic [55:0] lane_mul(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p);
    logic [55:0] r;
    r = '0;
    if (p == 2'd1) begin
      for (int i = 0; i < 2; i++) begin
        logic signed [11:0] pr;
        pr = $signed(a) * $signed(w[4*i +: 4]);
        r[28*i +: 28] = {{16{pr[11]}}, pr};
      end
    end else if (p == 2'd2) begin
      for (int i = 0; i < 4; i++) begin
        logic signed [9:0] pr;
        pr = $signed(a) * $signed(w[2*i +: 2]);
        r[14*i +: 14] = {{4{pr[9]}}, pr};
      end
    end else begin
      logic signed [15:0] pr;
      pr = $signed(a) * $signed(w);
      r = {{40{pr[15]}}, pr};
    end
    return r;
  endfunction

  function automatic logic [55:0] lane_add(input logic [55:0] a, input logic [55:0] b, input logic [1:0] p);
    logic [55:0] r;
    r = '0;
    if (p == 2'd1) begin
      for (int i = 0; i < 2; i++) r[28*i +: 28] = a[28*i +: 28] + b[28*i +: 28];
    end else if (p == 2'd2) begin
      for (int i = 0; i < 4; i++) r[14*i +: 14] = a[14*i +: 14] + b[14*i +: 14];
    end else begin
      r = a + b;
    end
    return r;
  endfunction

  logic [55:0] m_p, m_acc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_p   <= '0;
      m_acc <= '0;
    end else if (mac_clr) begin
      m_p   <= '0;
      m_acc <= '0;
    end else if (mac_en) begin
      m_acc <= lane_add(m_acc, m_p, mac_prec);
      m_p   <= lane_mul(mac_act, mac_wgt, mac_prec);
    end
  end
  assign mac_result = m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a job in IDLE; returns just after the accepting edge.
  task automatic start_job(input logic [1:0] p, input logic [LEN_W-1:0] n);
    cfg_valid = 1'b1;
    cfg_prec  = p;
    cfg_len   = n;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Offer n beats, inserting stall_len idle RUN cycles after stall_after beats; returns cycles used.
  task automatic feed(input int n, input logic [7:0] a, input logic [7:0] w,
                      input int stall_after, input int stall_len, output int cyc);
    int beats, stalled;
    logic rdy;
    beats = 0; stalled = 0; cyc = 0;
    while (beats < n && cyc < 200) begin
      in_valid = !(beats == stall_after && stalled < stall_len);
      in_act   = a;
      in_wgt   = w;
      @(negedge clk);
      rdy = in_ready;
      if (rdy && !in_valid) chk("stall_mac_en", {63'd0, mac_en}, 64'd0);
      tick();
      if (rdy && in_valid) beats++;
      else if (rdy) stalled++;
      cyc++;
    end
    in_valid = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
    if (cyc >= 200) chk("feed_timeout", 64'(cyc), 64'd0);
  endtask

  // Wait for res_valid within a bound; returns the number of edges waited.
  task automatic wait_res(output int w);
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 50) begin
      tick();
      w++;
      @(negedge clk);
    end
    if (!res_valid) chk("res_timeout", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  int cyc, w;

  initial begin
    rstn = 1'b0; cfg_valid = 1'b0; cfg_prec = '0; cfg_len = '0;
    in_valid = 1'b0; in_act = '0; in_wgt = '0; res_ready = 1'b0;
    #12;
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_outs", {in_ready, mac_en, mac_clr, res_valid, cfg_err, mac_prec, mac_act, mac_wgt},
        64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_perf", 64'(perf_stall), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // Full precision: 3 beats of 3*5.
    start_job(2'd0, 16'd3);
    chk("t1_clear", {62'd0, mac_clr, cfg_ready}, 64'b10);
    feed(3, 8'd3, 8'd5, 99, 0, cyc);
    chk("t1_flush", {61'd0, mac_en, in_ready, mac_act == 8'd0}, 64'b101);
    wait_res(w);
    chk("t1_latency", 64'(cyc + w), 64'd5);
    chk("t1_res", 64'(res_data), 64'd45);
    consume();
    chk("t1_idle", {63'd0, cfg_ready}, 64'd1);

    // 4b lanes.
    start_job(2'd1, 16'd2);
    chk("t2_prec_clear", 64'(mac_prec), 64'd1);
    feed(2, 8'd2, 8'h1F, 99, 0, cyc);
    wait_res(w);
    chk("t2_lane0", 64'(res_data[27:0]), 64'h0FFFFFFC);
    chk("t2_lane1", 64'(res_data[55:28]), 64'd4);
    chk("t2_res_prec", 64'(res_prec), 64'd1);
    chk("t2_prec_done", 64'(mac_prec), 64'd1);
    consume();
    chk("t2_prec_idle", 64'(mac_prec), 64'd0);

    // 2b lanes.
    start_job(2'd2, 16'd1);
    feed(1, 8'd3, 8'b01_11_10_01, 99, 0, cyc);
    wait_res(w);
    chk("t3_lane3", 64'(res_data[55:42]), 64'd3);
    chk("t3_lane2", 64'(res_data[41:28]), 64'h3FFD);
    chk("t3_lane1", 64'(res_data[27:14]), 64'h3FFA);
    chk("t3_lane0", 64'(res_data[13:0]), 64'd3);
    chk("t3_res_prec", 64'(res_prec), 64'd2);
    consume();

    // Stall mid-job and output backpressure.
    start_job(2'd0, 16'd4);
    feed(4, 8'd1, 8'd1, 2, 3, cyc);
    chk("t4_feed_cycles", 64'(cyc), 64'd8);
    wait_res(w);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", {7'd0, res_valid, res_data}, {8'd1, 56'd4});
      chk("t4_hold_en", {63'd0, mac_en}, 64'd0);
      tick();
      @(negedge clk);
    end
`ifdef MAC_JOB_SEQUENCER_PERF_EN
    chk("t4_perf", 64'(perf_stall), 64'd3);
`else
    chk("t4_perf", 64'(perf_stall), 64'd0);
`endif
    consume();

    // Illegal precision is rejected in IDLE.
    cfg_valid = 1'b1; cfg_prec = 2'd3; cfg_len = 16'd2;
    @(negedge clk);
    chk("t5_err", {62'd0, cfg_err, cfg_ready}, 64'b11);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("t5_still_idle", {62'd0, cfg_err, cfg_ready}, 64'b01);
    chk("t5_no_clr", {63'd0, mac_clr}, 64'd0);

    // Empty job: CLEAR, FLUSH, DONE with zero result.
    tick();
    start_job(2'd0, 16'd0);
    chk("t5_empty_clear", {63'd0, mac_clr}, 64'd1);
    tick();
    chk("t5_empty_flush", {62'd0, mac_en, in_ready}, 64'b10);
    tick();
    chk("t5_empty_done", {7'd0, res_valid, res_data}, {8'd1, 56'd0});
    consume();

    // Reset mid-RUN, then a clean job.
    start_job(2'd0, 16'd5);
    feed(2, 8'd4, 8'd4, 99, 0, cyc);
    chk("t6_mid_run", {63'd0, in_ready}, 64'd1);
    rstn = 1'b0;
    #2;
    chk("t6_rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("t6_rst_outs", {in_ready, mac_en, mac_clr, res_valid, cfg_err, mac_prec, mac_act, mac_wgt},
        64'd0);
    chk("t6_rst_res", 64'(res_data), 64'd0);
    chk("t6_rst_perf", 64'(perf_stall), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    start_job(2'd0, 16'd1);
    feed(1, 8'hFE, 8'd7, 99, 0, cyc);
    wait_res(w);
    chk("t6_res", 64'(res_data), 64'h00FFFFFFFFFFFFF2);
    consume();
    chk("t6_idle", {63'd0, cfg_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
